// File: rtl/arf_pkg.sv
// Shared types and constants for the sequential ARF-variance executor:
// operation encoding, schedule entry layout, register-file map, the default
// 28-step schedule and the constant bank loaded into RF[10..15].
package arf_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_MUL = 1'b1
  } op_t;

  typedef struct packed {
    op_t        op;
    logic [5:0] srca;
    logic [5:0] srcb;
    logic [5:0] dst;
  } sched_t;

  // Register-file map: 0..9 inputs, 10..15 constants, 16..63 temporaries.
  localparam int ARF_RF_DEPTH    = 64;
  localparam int ARF_NIN         = 10;
  localparam int ARF_FIRST_CONST = 10;
  localparam int ARF_NCONST      = 6;
  localparam int ARF_FIRST_TMP   = 16;

  localparam int ARF_NSTEP = 28;

  // Graph node n lives at RF[15+n]; the two results are nodes 27 and 28.
  localparam int ARF_OUT27_IDX = 42;
  localparam int ARF_OUT28_IDX = 43;

  function automatic sched_t arf_step(input op_t op, input int a, input int b, input int d);
    sched_t s;
    s.op   = op;
    s.srca = 6'(a);
    s.srcb = 6'(b);
    s.dst  = 6'(d);
    return s;
  endfunction

  localparam logic signed [15:0] ARF_CONST [ARF_NCONST] = '{
    16'sd3, -16'sd2, 16'sd5, 16'sd7, -16'sd1, 16'sd2
  };

  // Two 4-tap lattice sections feeding a cross-product variance stage.
  localparam sched_t ARF_SCHED [ARF_NSTEP] = '{
    arf_step(OP_MUL,  0, 10, 16),  // n1  = x1 * k0
    arf_step(OP_MUL,  1, 11, 17),  // n2  = x2 * k1
    arf_step(OP_MUL,  2, 12, 18),  // n3  = x3 * k2
    arf_step(OP_MUL,  3, 13, 19),  // n4  = x4 * k3
    arf_step(OP_ADD, 16, 17, 20),  // n5  = n1 + n2
    arf_step(OP_ADD, 18, 19, 21),  // n6  = n3 + n4
    arf_step(OP_MUL, 20, 14, 22),  // n7  = n5 * k4
    arf_step(OP_MUL, 21, 15, 23),  // n8  = n6 * k5
    arf_step(OP_MUL, 20, 15, 24),  // n9  = n5 * k5
    arf_step(OP_MUL, 21, 14, 25),  // n10 = n6 * k4
    arf_step(OP_ADD, 22, 23, 26),  // n11 = n7 + n8
    arf_step(OP_ADD, 24, 25, 27),  // n12 = n9 + n10
    arf_step(OP_ADD, 26,  8, 28),  // n13 = n11 + x13
    arf_step(OP_ADD, 27,  9, 29),  // n14 = n12 + x14
    arf_step(OP_MUL,  4, 10, 30),  // n15 = x5 * k0
    arf_step(OP_MUL,  5, 11, 31),  // n16 = x6 * k1
    arf_step(OP_MUL,  6, 12, 32),  // n17 = x7 * k2
    arf_step(OP_MUL,  7, 13, 33),  // n18 = x8 * k3
    arf_step(OP_ADD, 30, 31, 34),  // n19 = n15 + n16
    arf_step(OP_ADD, 32, 33, 35),  // n20 = n17 + n18
    arf_step(OP_MUL, 28, 34, 36),  // n21 = n13 * n19
    arf_step(OP_MUL, 29, 35, 37),  // n22 = n14 * n20
    arf_step(OP_MUL, 28, 35, 38),  // n23 = n13 * n20
    arf_step(OP_MUL, 29, 34, 39),  // n24 = n14 * n19
    arf_step(OP_MUL, 36, 14, 40),  // n25 = n21 * k4
    arf_step(OP_MUL, 37, 15, 41),  // n26 = n22 * k5
    arf_step(OP_ADD, 40, 41, 42),  // n27 = n25 + n26
    arf_step(OP_ADD, 38, 39, 43)   // n28 = n23 + n24
  };

endpackage

// File: rtl/arf_alu.sv
// Shared arithmetic unit: one signed multiplier (truncated to DW bits) and
// one signed adder. Define ARF_SEQ_SAT_EN to make the adder saturate; the
// default build wraps modulo 2^DW.
module arf_alu
  import arf_pkg::*;
#(
  parameter int DW = 16
)(
  input  op_t                  op,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic signed [DW-1:0] y
);

  function automatic logic signed [DW-1:0] mul_trunc(input logic signed [DW-1:0] x,
                                                      input logic signed [DW-1:0] z);
    logic signed [2*DW-1:0] p;
    p = x * z;
    return p[DW-1:0];
  endfunction

  function automatic logic signed [DW-1:0] add_fix(input logic signed [DW-1:0] x,
                                                    input logic signed [DW-1:0] z);
    logic signed [DW:0] s;
    logic signed [DW-1:0] r;
    s = {x[DW-1], x} + {z[DW-1], z};
`ifdef ARF_SEQ_SAT_EN
    // Sign bits disagree only on overflow; clamp toward the true sign.
    if (s[DW] != s[DW-1])
      r = s[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    else
      r = s[DW-1:0];
`else
    r = s[DW-1:0];
`endif
    return r;
  endfunction

  // Select the result of the requested operation.
  always_comb begin
    y = add_fix(a, b);
    if (op == OP_MUL) y = mul_trunc(a, b);
  end

endmodule

// File: rtl/arf_seq_exec.sv
// Time-multiplexed executor of the ARF-variance graph: a 64-entry register
// file, one shared ALU (arf_alu) and an IDLE/EXEC/DONE controller that walks
// the schedule one entry per cycle. ARF_SEQ_SAT_EN selects saturating adds.
module arf_seq_exec
  import arf_pkg::*;
#(
  parameter int     DW            = 16,
  parameter int     NSTEP         = ARF_NSTEP,
  parameter sched_t SCHED [NSTEP] = ARF_SCHED,
  parameter int     OUT_A_IDX     = ARF_OUT27_IDX,
  parameter int     OUT_B_IDX     = ARF_OUT28_IDX
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [10*DW-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_a,
  output logic [DW-1:0]    out_b,
  output logic             busy
);

  localparam int SW = (NSTEP > 1) ? $clog2(NSTEP) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t               state_q, state_d;
  logic [SW-1:0]        step_q;
  logic signed [DW-1:0] rf [ARF_RF_DEPTH];
  sched_t               ent;
  logic signed [DW-1:0] alu_y;
  logic                 accept, last_step, wr_en;
  logic signed [DW-1:0] cap_a, cap_b;

  assign ent       = SCHED[step_q];
  assign accept    = in_valid && in_ready;
  assign last_step = (state_q == EXEC) && (step_q == SW'(NSTEP - 1));
  // Inputs and constants are read-only to the schedule.
  assign wr_en     = (state_q == EXEC) && (ent.dst >= 6'(ARF_FIRST_TMP));

  arf_alu #(.DW(DW)) u_alu (
    .op (ent.op),
    .a  (rf[ent.srca]),
    .b  (rf[ent.srcb]),
    .y  (alu_y)
  );

  // The last step's result is not in the RF yet when DONE is entered, so
  // forward it if it targets an output index.
  assign cap_a = (wr_en && ent.dst == 6'(OUT_A_IDX)) ? alu_y : rf[OUT_A_IDX];
  assign cap_b = (wr_en && ent.dst == 6'(OUT_B_IDX)) ? alu_y : rf[OUT_B_IDX];

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake outputs; in_ready is held low during reset.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        busy     = 1'b0;
        in_ready = rst_n;
        if (in_valid && rst_n) state_d = EXEC;
      end
      EXEC: begin
        if (last_step) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Schedule step counter: restarts on accept, advances each EXEC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         step_q <= '0;
    else if (accept)                    step_q <= '0;
    else if (state_q == EXEC && !last_step) step_q <= step_q + 1'b1;
  end

  // Register file: constants reloaded on reset, inputs on accept, temps per step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ARF_RF_DEPTH; i++) rf[i] <= '0;
      for (int i = 0; i < ARF_NCONST; i++)   rf[ARF_FIRST_CONST + i] <= DW'(ARF_CONST[i]);
    end else if (accept) begin
      for (int i = 0; i < ARF_NIN; i++)      rf[i] <= in_data[i*DW +: DW];
    end else if (wr_en) begin
      rf[ent.dst] <= alu_y;
    end
  end

  // Result registers: captured on DONE entry and held through any stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_a <= '0;
      out_b <= '0;
    end else if (last_step) begin
      out_a <= cap_a;
      out_b <= cap_b;
    end
  end

endmodule

// File: tb/tb_arf_seq_exec.sv
// Bench for arf_seq_exec: a two-step directed schedule, a constant-protection
// schedule and the default ARF schedule against a golden graph model.
module tb_arf_seq_exec;
  import arf_pkg::*;

  localparam int DW = 16;
  localparam sched_t SMALL_SCHED [2] = '{arf_step(OP_MUL, 0, 1, 16), arf_step(OP_ADD, 16, 2, 17)};
  localparam sched_t PROT_SCHED  [2] = '{arf_step(OP_ADD, 0, 1, 10), arf_step(OP_ADD, 10, 2, 16)};

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [10*DW-1:0] in_data = '0;
  int               sel = 0;

  logic             iv_s, iv_p, iv_f;
  logic             rdy_s, rdy_p, rdy_f, ov_s, ov_p, ov_f, bsy_s, bsy_p, bsy_f;
  logic [DW-1:0]    oa_s, oa_p, oa_f, ob_s, ob_p, ob_f;
  logic             rdy_m, ov_m, bsy_m;
  logic [DW-1:0]    oa_m, ob_m;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int ntaken = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign iv_s  = in_valid && (sel == 0);
  assign iv_p  = in_valid && (sel == 1);
  assign iv_f  = in_valid && (sel == 2);
  assign rdy_m = (sel == 0) ? rdy_s : (sel == 1) ? rdy_p : rdy_f;
  assign ov_m  = (sel == 0) ? ov_s  : (sel == 1) ? ov_p  : ov_f;
  assign bsy_m = (sel == 0) ? bsy_s : (sel == 1) ? bsy_p : bsy_f;
  assign oa_m  = (sel == 0) ? oa_s  : (sel == 1) ? oa_p  : oa_f;
  assign ob_m  = (sel == 0) ? ob_s  : (sel == 1) ? ob_p  : ob_f;

  arf_seq_exec #(.DW(DW), .NSTEP(2), .SCHED(SMALL_SCHED), .OUT_A_IDX(16), .OUT_B_IDX(17)) u_small (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_s), .in_ready(rdy_s), .in_data(in_data),
    .out_valid(ov_s), .out_ready(out_ready), .out_a(oa_s), .out_b(ob_s), .busy(bsy_s));

  arf_seq_exec #(.DW(DW), .NSTEP(2), .SCHED(PROT_SCHED), .OUT_A_IDX(10), .OUT_B_IDX(16)) u_prot (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_p), .in_ready(rdy_p), .in_data(in_data),
    .out_valid(ov_p), .out_ready(out_ready), .out_a(oa_p), .out_b(ob_p), .busy(bsy_p));

  arf_seq_exec #(.DW(DW)) u_full (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_f), .in_ready(rdy_f), .in_data(in_data),
    .out_valid(ov_f), .out_ready(out_ready), .out_a(oa_f), .out_b(ob_f), .busy(bsy_f));

  // ---------------- golden model ----------------
  function automatic logic [15:0] m16(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] p;
    p = $signed(a) * $signed(b);
    return p[15:0];
  endfunction

  function automatic logic [15:0] a16(input logic [15:0] a, input logic [15:0] b);
    logic signed [16:0] s;
    s = $signed({a[15], a}) + $signed({b[15], b});
`ifdef ARF_SEQ_SAT_EN
    if (s > 17'sd32767)       return 16'h7FFF;
    else if (s < -17'sd32768) return 16'h8000;
`endif
    return s[15:0];
  endfunction

  function automatic logic [31:0] golden(input logic [15:0] x [10]);
    logic [15:0] k0, k1, k2, k3, k4, k5;
    logic [15:0] n1, n2, n3, n4, n5, n6, n7, n8, n9, n10, n11, n12, n13, n14;
    logic [15:0] n15, n16, n17, n18, n19, n20, n21, n22, n23, n24, n25, n26, n27, n28;
    k0 = 16'd3; k1 = 16'hFFFE; k2 = 16'd5; k3 = 16'd7; k4 = 16'hFFFF; k5 = 16'd2;
    n1 = m16(x[0], k0);  n2 = m16(x[1], k1);  n3 = m16(x[2], k2);  n4 = m16(x[3], k3);
    n5 = a16(n1, n2);    n6 = a16(n3, n4);
    n7 = m16(n5, k4);    n8 = m16(n6, k5);    n9 = m16(n5, k5);    n10 = m16(n6, k4);
    n11 = a16(n7, n8);   n12 = a16(n9, n10);
    n13 = a16(n11, x[8]); n14 = a16(n12, x[9]);
    n15 = m16(x[4], k0); n16 = m16(x[5], k1); n17 = m16(x[6], k2); n18 = m16(x[7], k3);
    n19 = a16(n15, n16); n20 = a16(n17, n18);
    n21 = m16(n13, n19); n22 = m16(n14, n20); n23 = m16(n13, n20); n24 = m16(n14, n19);
    n25 = m16(n21, k4);  n26 = m16(n22, k5);
    n27 = a16(n25, n26); n28 = a16(n23, n24);
    return {n27, n28};
  endfunction

  function automatic logic [10*DW-1:0] pack3(input logic [15:0] w0, input logic [15:0] w1,
                                             input logic [15:0] w2);
    logic [10*DW-1:0] d;
    d = '0;
    d[15:0] = w0; d[31:16] = w1; d[47:32] = w2;
    return d;
  endfunction

  // ---------------- check helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input string tag, input logic [10*DW-1:0] d);
    int n;
    n = 0;
    @(negedge clk);
    in_data  = d;
    in_valid = 1'b1;
    while (!rdy_m && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_accept"}, 32'(rdy_m), 32'd1);
    acc_cyc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int lat_exp);
    int n;
    n = 0;
    while (!ov_m && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(ov_m), 32'd1);
    chk({tag, "_latency"}, 32'(cyc - acc_cyc), 32'(lat_exp));
  endtask

  task automatic stall(input string tag, input int n);
    logic [15:0] pa, pb;
    pa = oa_m;
    pb = ob_m;
    for (int i = 0; i < n; i++) begin
      out_ready = 1'b0;
      @(negedge clk);
      chk({tag, "_hold_valid"}, 32'(ov_m), 32'd1);
      chk({tag, "_hold_a"}, 32'(oa_m), 32'(pa));
      chk({tag, "_hold_b"}, 32'(ob_m), 32'(pb));
      chk({tag, "_hold_inready"}, 32'(rdy_m), 32'd0);
      chk({tag, "_hold_busy"}, 32'(bsy_m), 32'd1);
    end
  endtask

  task automatic take(input string tag);
    logic [31:0] e;
    chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_out_a"}, 32'(oa_m), 32'(e[31:16]));
      chk({tag, "_out_b"}, 32'(ob_m), 32'(e[15:0]));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    ntaken++;
    chk({tag, "_no_dup"}, 32'(ov_m), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] x [10];
    logic [31:0] e;
    int          nfull;

    // Reset values while rst_n is low, then in_ready right after release.
    #1;
    for (int i = 0; i < 3; i++) begin
      sel = i;
      #1;
      chk("rst_out_valid", 32'(ov_m), 32'd0);
      chk("rst_out_a", 32'(oa_m), 32'd0);
      chk("rst_out_b", 32'(ob_m), 32'd0);
      chk("rst_in_ready", 32'(rdy_m), 32'd0);
      chk("rst_busy", 32'(bsy_m), 32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      sel = i;
      #1;
      chk("post_rst_in_ready", 32'(rdy_m), 32'd1);
    end
    sel = 0;

    // Small schedule: 3*4=12, 12+5=17, valid three cycles after accept.
    sb.push_back({16'd12, 16'd17});
    send("basic", pack3(16'd3, 16'd4, 16'd5));
    wait_valid("basic", 3);
    take("basic");

    // Add overflow: 0x7FFF*1 + 1.
`ifdef ARF_SEQ_SAT_EN
    sb.push_back({16'h7FFF, 16'h7FFF});
`else
    sb.push_back({16'h7FFF, 16'h8000});
`endif
    send("ovf", pack3(16'h7FFF, 16'd1, 16'd1));
    wait_valid("ovf", 3);
    take("ovf");

    // Negative operands: -6*7 = -42, -42 + -8 = -50.
    sb.push_back({16'hFFD6, 16'hFFCE});
    send("neg", pack3(16'hFFFA, 16'd7, 16'hFFF8));
    wait_valid("neg", 3);
    take("neg");

    // Ten-cycle sink stall with a competing input offered meanwhile.
    sb.push_back({16'd6, 16'd10});
    send("stall", pack3(16'd2, 16'd3, 16'd4));
    wait_valid("stall", 3);
    in_data  = pack3(16'd100, 16'd100, 16'd100);
    in_valid = 1'b1;
    stall("stall", 10);
    in_valid = 1'b0;
    take("stall");

    // Writes to the constant region are dropped; RF[10] stays 3.
    sel = 1;
    sb.push_back({16'd3, 16'd103});
    send("prot1", pack3(16'd7, 16'd9, 16'd100));
    wait_valid("prot1", 3);
    take("prot1");
    sb.push_back({16'd3, 16'hFFFF});
    send("prot2", pack3(16'd7, 16'd9, 16'hFFFC));
    wait_valid("prot2", 3);
    take("prot2");

    // Reset during step 1 drops the sample.
    sel = 0;
    send("midrst", pack3(16'd3, 16'd4, 16'd5));
    @(negedge clk);
    chk("midrst_busy", 32'(bsy_m), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(ov_m), 32'd0);
    chk("midrst_out_a", 32'(oa_m), 32'd0);
    chk("midrst_out_b", 32'(ob_m), 32'd0);
    chk("midrst_in_ready", 32'(rdy_m), 32'd0);
    chk("midrst_busy_low", 32'(bsy_m), 32'd0);
    #1;
    rst_n = 1'b1;
    #1;
    chk("midrst_release_ready", 32'(rdy_m), 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("midrst_no_valid", 32'(ov_m), 32'd0);
    end

    // Default schedule against the golden graph, random sink stalls.
    sel = 2;
    nfull = ntaken;
    for (int s = 0; s < 100; s++) begin
      for (int i = 0; i < 10; i++) begin
        if (s == 0)      x[i] = 16'h0000;
        else if (s == 1) x[i] = 16'h7FFF;
        else if (s == 2) x[i] = 16'h8000;
        else if (s == 3) x[i] = 16'(i + 1);
        else             x[i] = 16'($urandom);
      end
      e = golden(x);
      sb.push_back(e);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send("graph", {x[9], x[8], x[7], x[6], x[5], x[4], x[3], x[2], x[1], x[0]});
      wait_valid("graph", ARF_NSTEP + 1);
      stall("graph", $urandom_range(0, 3));
      take("graph");
    end
    chk("graph_count", 32'(ntaken - nfull), 32'd100);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/arf_seq_exec.md
ARF_SEQ_EXEC -- requirements
Module: arf_seq_exec

Interface
REQ-001 SHALL have parameter DW, default 16, meaning the data word width in bits.
REQ-002 SHALL have parameter NSTEP, default arf_pkg::ARF_NSTEP (28), meaning the number of schedule steps executed per sample.
REQ-003 SHALL have parameter SCHED, default arf_pkg::ARF_SCHED, meaning the schedule table of NSTEP entries, each {op, srcA, srcB, dst}.
REQ-004 SHALL have parameter OUT_A_IDX, default arf_pkg::ARF_OUT27_IDX, meaning the register-file index driven onto out_a.
REQ-005 SHALL have parameter OUT_B_IDX, default arf_pkg::ARF_OUT28_IDX, meaning the register-file index driven onto out_b.
REQ-006 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-008 SHALL have port in_valid, input, 1 bit: a sample is present on in_data.
REQ-009 SHALL have port in_ready, output, 1 bit: the block accepts a sample this cycle.
REQ-010 SHALL have port in_data, input, 10*DW bits: operand words 0..9 (in_1_0..in_8_0, in_13_1, in_14_1), with word 0 in the LSBs.
REQ-011 SHALL have port out_valid, output, 1 bit: out_a and out_b hold a result.
REQ-012 SHALL have port out_ready, input, 1 bit: the sink takes the result.
REQ-013 SHALL have port out_a, output, DW bits: result node 27.
REQ-014 SHALL have port out_b, output, DW bits: result node 28.
REQ-015 SHALL have port busy, output, 1 bit: high whenever the FSM is not IDLE.

Function
REQ-016 SHALL be a time-multiplexed executor of the scheduled ARF-variance graph with exactly one multiplier and one adder.
REQ-017 SHALL hold a 64-entry DW-bit register file (RF): entries 0..9 inputs, 10..15 constants, 16..63 temporaries.
REQ-018 SHALL implement FSM states IDLE, EXEC and DONE.
REQ-019 SHALL, in IDLE: drive in_ready=1; on in_valid&&in_ready write in_data words to RF[0..9], clear the step counter and move to EXEC.
REQ-020 SHALL, in EXEC: execute one schedule entry per cycle, RF[dst] <= RF[srcA] op RF[srcB], with the write visible to the next step.
REQ-021 SHALL, after step NSTEP-1, move to DONE.
REQ-022 SHALL compute mul as the low DW bits of the signed product.
REQ-023 SHALL compute add as signed DW-bit addition, with overflow behaviour per REQ-036/037.
REQ-024 SHALL, on DONE entry, register out_a=RF[OUT_A_IDX] and out_b=RF[OUT_B_IDX], and assert out_valid.
REQ-025 SHALL hold out_valid, out_a and out_b stable until out_ready, then return to IDLE.
REQ-026 SHALL keep in_ready=0 in EXEC and DONE; in_valid in those states is ignored.
REQ-027 SHALL assert out_valid exactly NSTEP+1 cycles after the accept edge.
REQ-028 SHALL sustain throughput of one sample per NSTEP+2 cycles when out_ready is tied high.
REQ-029 SHALL treat a schedule entry with dst in 0..15 as a no-op write (inputs and constants are protected).
REQ-030 SHALL ensure a stall of out_ready never corrupts RF or outputs.

Reset
REQ-031 SHALL, when rst_n=0, immediately force FSM=IDLE and step counter=0.
REQ-032 SHALL, when rst_n=0, immediately drive out_valid=0, out_a=0, out_b=0, in_ready=0 and busy=0.
REQ-033 SHALL, while rst_n=0, load RF[10..15] from arf_pkg::ARF_CONST and clear all other RF entries.
REQ-034 SHALL drive in_ready=1 in the first cycle after rst_n deasserts.
REQ-035 SHALL, on reset mid-EXEC or mid-DONE, drop the sample silently and produce no out_valid.

Configuration
REQ-036 SHALL, with ARF_SEQ_SAT_EN defined, make adds saturate to [-2^(DW-1), 2^(DW-1)-1].
REQ-037 SHALL, without ARF_SEQ_SAT_EN defined, make adds wrap modulo 2^DW; mul is truncating in both builds.

Structure
REQ-038 SHALL place the op enum (OP_ADD, OP_MUL), the schedule entry struct, ARF_NSTEP, ARF_SCHED, ARF_CONST and the output indices in package arf_pkg.
REQ-039 SHALL implement the arithmetic (both ops, including the saturation option) in sub-module arf_alu; the FSM and RF stay in arf_seq_exec.

Verification
REQ-040 SHALL cover: with NSTEP=2, SCHED={MUL 0,1->16; ADD 16,2->17}, OUT_A_IDX=16, OUT_B_IDX=17, words 3,4,5 -> out_a=12, out_b=17, out_valid 3 cycles after accept.
REQ-041 SHALL cover: the same schedule with words 0x7FFF,1,1 -> out_b=0x7FFF with ARF_SEQ_SAT_EN, 0x8000 without.
REQ-042 SHALL cover: out_ready held 0 for 10 cycles -> out_valid, out_a and out_b stable; in_ready=0 throughout.
REQ-043 SHALL cover: rst_n pulsed low at step 1 -> out_valid never asserts; in_ready=1 the cycle after release.
REQ-044 SHALL cover: default schedule, 100 random samples with out_ready random -> outputs equal the golden combinational graph model; no sample lost or duplicated.
REQ-045 SHALL cover: schedule entry with dst=10 -> RF[10] constant unchanged on the next sample.
